// File: rtl/cmd_player_pkg.sv
// Shared types for the command player: opcodes, the script entry layout
// and the per-channel state encoding.
package cmd_player_pkg;

  // Command opcodes; DEL is the idle/neutral value driven when no command is valid.
  typedef enum logic [1:0] {
    DEL   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FLUSH = 2'd3
  } opcode;

  localparam int ID_SZ = 4;

  // One script entry. last marks the final entry of the script.
  typedef struct packed {
    opcode              op;
    logic               mo;
    logic [ID_SZ-1:0]   id;
    logic               last;
  } cmd_t;

  // Per-channel playback state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } ch_state_t;

endpackage

// File: rtl/cmd_player_if.sv
// Host-side load/control bus and consumer-side command channels of the
// command player, bundled for all NCH channels.
//
// Command handshake: a command transfers on every rising clk edge where
// vld[c] && rdy[c]. While vld[c] is high the payload op/mo/id of channel c
// is held stable and vld[c] is never withdrawn until that transfer happens.
// rdy[c] may change freely and carries no obligation on the player.
interface cmd_player_if
  import cmd_player_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 16,
  parameter int GAP_W = 8
) ();
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  // script load port
  logic                   ld_en;
  logic [CW-1:0]          ld_ch;
  logic [AW-1:0]          ld_addr;
  opcode                  ld_op;
  logic                   ld_mo;
  logic [ID_SZ-1:0]       ld_id;
  logic                   ld_last;
  logic                   ld_err;

  // per-channel control
  logic [NCH-1:0]         start;
  logic [NCH-1:0]         stop;
  logic [NCH-1:0]         loop;
  logic [NCH*GAP_W-1:0]   gap;

  // per-channel command output
  logic [NCH-1:0]         vld;
  logic [NCH-1:0]         rdy;
  opcode [NCH-1:0]        op;
  logic [NCH-1:0]         mo;
  logic [NCH*ID_SZ-1:0]   id;

  // per-channel status and debug state
  logic [NCH-1:0]         busy;
  logic [NCH-1:0]         done;
  logic [NCH*16-1:0]      sent;
  ch_state_t [NCH-1:0]    st;

  modport slave (
    input  ld_en, ld_ch, ld_addr, ld_op, ld_mo, ld_id, ld_last,
    input  start, stop, loop, gap, rdy,
    output ld_err, vld, op, mo, id, busy, done, sent, st
  );

  modport master (
    output ld_en, ld_ch, ld_addr, ld_op, ld_mo, ld_id, ld_last,
    output start, stop, loop, gap, rdy,
    input  ld_err, vld, op, mo, id, busy, done, sent, st
  );

endinterface

// File: rtl/cmd_player_ch.sv
// One playback channel: script RAM, IDLE/SEND/GAP sequencer, handshake
// counter and command outputs.
module cmd_player_ch
  import cmd_player_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GAP_W = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  cmd_t             wr_cmd_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             loop_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             rdy_i,
  output logic             vld_o,
  output opcode            op_o,
  output logic             mo_o,
  output logic [ID_SZ-1:0] id_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      sent_o,
  output ch_state_t        state_o
);

  cmd_t             mem_q [DEPTH];

  ch_state_t        state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [15:0]      sent_q, sent_d;
  logic             loop_q, loop_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             stop_pend_q, stop_pend_d;
  logic             done_q, done_d;

  cmd_t             cur;
  logic             eos;

  // Payload is read straight from the RAM; writes are only accepted while
  // idle, so the entry under ptr cannot change while it is being offered.
  assign cur = mem_q[ptr_q];
  assign eos = cur.last || (ptr_q == AW'(DEPTH - 1));

  // Script RAM write port; deliberately not reset so scripts survive rst.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_cmd_i;
    end
  end

  // Sequencer state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      sent_q      <= '0;
      loop_q      <= 1'b0;
      gap_q       <= '0;
      gcnt_q      <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sent_q      <= sent_d;
      loop_q      <= loop_d;
      gap_q       <= gap_d;
      gcnt_q      <= gcnt_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: start/stop handling, end-of-script, looping and gaps.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sent_d      = sent_q;
    loop_d      = loop_q;
    gap_d       = gap_q;
    gcnt_d      = gcnt_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // stop in the same cycle as start cancels it
        if (start_i && !stop_i) begin
          state_d     = ST_SEND;
          ptr_d       = '0;
          sent_d      = '0;
          loop_d      = loop_i;
          gap_d       = gap_i;
          stop_pend_d = 1'b0;
        end
      end

      ST_SEND: begin
        if (stop_i) begin
          stop_pend_d = 1'b1;
        end
        if (rdy_i) begin
          sent_d = (sent_q == 16'hFFFF) ? sent_q : sent_q + 16'd1;
          // a stop arriving in the handshake cycle itself ends playback here too
          if ((eos && !loop_q) || stop_pend_q || stop_i) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            ptr_d = eos ? '0 : ptr_q + AW'(1);
            if (gap_q == '0) begin
              state_d = ST_SEND;
            end else begin
              state_d = ST_GAP;
              gcnt_d  = gap_q;
            end
          end
        end
      end

      ST_GAP: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (gcnt_q <= GAP_W'(1)) begin
          state_d = ST_SEND;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign vld_o   = (state_q == ST_SEND);
  assign op_o    = vld_o ? cur.op : DEL;
  assign mo_o    = vld_o ? cur.mo : 1'b0;
  assign id_o    = vld_o ? cur.id : '0;
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;
  assign sent_o  = sent_q;
  assign state_o = state_q;

endmodule

// File: rtl/cmd_player.sv
// Multi-channel command player: one cmd_player_ch per channel, plus load
// decode and rejection of script writes aimed at a busy channel.
module cmd_player
  import cmd_player_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 16,
  parameter int GAP_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  cmd_player_if.slave   cp
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]        sel_w;
  logic [NCH-1:0]        vld_w;
  logic [NCH-1:0]        mo_w;
  logic [NCH-1:0]        busy_w;
  logic [NCH-1:0]        done_w;
  opcode [NCH-1:0]       op_w;
  logic [NCH*ID_SZ-1:0]  id_w;
  logic [NCH*16-1:0]     sent_w;
  ch_state_t [NCH-1:0]   st_w;
  cmd_t                  ld_cmd;
  logic                  ld_err_q, ld_err_d;

  assign ld_cmd = '{op: cp.ld_op, mo: cp.ld_mo, id: cp.ld_id, last: cp.ld_last};

  // Decode which channel the current load strobe targets.
  always_comb begin
    sel_w = '0;
    for (int c = 0; c < NCH; c++) begin
      sel_w[c] = cp.ld_en && (cp.ld_ch == CW'(c));
    end
  end

  assign ld_err_d = |(sel_w & busy_w);

  // Rejection pulse, aligned with the edge at which the write would have landed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_err_q <= 1'b0;
    end else begin
      ld_err_q <= ld_err_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    cmd_player_ch #(
      .DEPTH (DEPTH),
      .GAP_W (GAP_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (sel_w[c] && !busy_w[c]),
      .wr_addr_i (cp.ld_addr),
      .wr_cmd_i  (ld_cmd),
      .start_i   (cp.start[c]),
      .stop_i    (cp.stop[c]),
      .loop_i    (cp.loop[c]),
      .gap_i     (cp.gap[c*GAP_W +: GAP_W]),
      .rdy_i     (cp.rdy[c]),
      .vld_o     (vld_w[c]),
      .op_o      (op_w[c]),
      .mo_o      (mo_w[c]),
      .id_o      (id_w[c*ID_SZ +: ID_SZ]),
      .busy_o    (busy_w[c]),
      .done_o    (done_w[c]),
      .sent_o    (sent_w[c*16 +: 16]),
      .state_o   (st_w[c])
    );
  end

  assign cp.ld_err = ld_err_q;
  assign cp.vld    = vld_w;
  assign cp.op     = op_w;
  assign cp.mo     = mo_w;
  assign cp.id     = id_w;
  assign cp.busy   = busy_w;
  assign cp.done   = done_w;
  assign cp.sent   = sent_w;
  assign cp.st     = st_w;

endmodule

// File: tb/tb_cmd_player.sv
// Directed bench for cmd_player (NCH=2): playback, gaps, stalls, looping
// with stop, busy-load rejection and reset behaviour.
module tb_cmd_player;
  import cmd_player_pkg::*;

  localparam int NCH   = 2;
  localparam int DEPTH = 16;
  localparam int GAP_W = 8;
  localparam int W     = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_player_if #(.NCH(NCH), .DEPTH(DEPTH), .GAP_W(GAP_W)) cp ();

  cmd_player #(.NCH(NCH), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk (clk),
    .rst (rst),
    .cp  (cp)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic sb_en = 1'b0;

  logic [W-1:0] e0, e1, e2;
  logic [7:0]   pat, dn, bz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pay(input opcode o, input logic m, input logic [ID_SZ-1:0] i);
    return {o, m, i};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int addr, input opcode o, input logic m,
                      input int i, input logic l);
    cp.ld_en   = 1'b1;
    cp.ld_ch   = ch[0];
    cp.ld_addr = addr[3:0];
    cp.ld_op   = o;
    cp.ld_mo   = m;
    cp.ld_id   = i[3:0];
    cp.ld_last = l;
    step();
    cp.ld_en   = 1'b0;
  endtask

  task automatic pulse_start(input logic [NCH-1:0] m);
    cp.start = m;
    step();
    cp.start = '0;
  endtask

  task automatic wait_done0(input string tag);
    int n;
    n = 0;
    while (!cp.done[0] && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(cp.done[0]), 32'd1);
  endtask

  // Scoreboard on channel 0: each handshake must match the next expected entry.
  always @(negedge clk) begin
    logic [31:0] e;
    if (sb_en && cp.vld[0] && cp.rdy[0]) begin
      if (exp_q.size() > 0) e = 32'(exp_q.pop_front());
      else                  e = 32'hFFFF_FFFF;
      chk("sb_cmd", 32'({cp.op[0], cp.mo[0], cp.id[3:0]}), e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    e0 = pay(READ, 1'b0, 4'd0);
    e1 = pay(WRITE, 1'b1, 4'd1);
    e2 = pay(FLUSH, 1'b0, 4'd2);

    rst = 1'b1;
    cp.ld_en = 1'b0; cp.ld_ch = '0; cp.ld_addr = '0; cp.ld_op = DEL;
    cp.ld_mo = 1'b0; cp.ld_id = '0; cp.ld_last = 1'b0;
    cp.start = '0; cp.stop = '0; cp.loop = '0; cp.gap = '0; cp.rdy = '0;
    step();
    step();

    // reset state
    chk("rst_vld",  32'(cp.vld), 0);
    chk("rst_busy", 32'(cp.busy), 0);
    chk("rst_done", 32'(cp.done), 0);
    chk("rst_err",  32'(cp.ld_err), 0);
    chk("rst_sent", cp.sent, 0);
    chk("rst_op",   32'(cp.op), 0);
    chk("rst_id",   32'(cp.id), 0);
    chk("rst_st",   32'(cp.st), 0);
    rst = 1'b0;

    load(0, 0, READ,  1'b0, 0, 1'b0);
    load(0, 1, WRITE, 1'b1, 1, 1'b0);
    load(0, 2, FLUSH, 1'b0, 2, 1'b1);
    load(1, 0, WRITE, 1'b0, 5, 1'b0);
    load(1, 1, READ,  1'b1, 6, 1'b1);
    chk("ld_ok_err", 32'(cp.ld_err), 0);

    // back-to-back playback
    cp.rdy = 2'b11;
    sb_en = 1'b1;
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
    pulse_start(2'b01);
    chk("t1_vld0", 32'(cp.vld[0]), 1);
    chk("t1_id0",  32'(cp.id[3:0]), 0);
    step();
    chk("t1_id1",  32'(cp.id[3:0]), 1);
    chk("t1_op1",  32'(cp.op[0]), 32'(WRITE));
    step();
    chk("t1_id2",  32'(cp.id[3:0]), 2);
    step();
    chk("t1_done", 32'(cp.done[0]), 1);
    chk("t1_busy", 32'(cp.busy[0]), 0);
    chk("t1_vld_end", 32'(cp.vld[0]), 0);
    chk("t1_sent", 32'(cp.sent[15:0]), 3);
    chk("t1_op_idle", 32'(cp.op[0]), 32'(DEL));
    step();
    chk("t1_done_pulse", 32'(cp.done[0]), 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // gap of two idle cycles between commands
    cp.gap = {8'd0, 8'd2};
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
    pulse_start(2'b01);
    for (int i = 0; i < 8; i++) begin
      pat[i] = cp.vld[0];
      dn[i]  = cp.done[0];
      bz[i]  = cp.busy[0];
      step();
    end
    chk("t2_vld_pat",  32'(pat), 32'h49);
    chk("t2_done_pat", 32'(dn),  32'h80);
    chk("t2_busy_pat", 32'(bz),  32'h7F);
    chk("t2_sent", 32'(cp.sent[15:0]), 3);
    cp.gap = '0;

    // consumer stall on entry 1
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
    pulse_start(2'b01);
    chk("t3_id0", 32'(cp.id[3:0]), 0);
    step();
    chk("t3_id1", 32'(cp.id[3:0]), 1);
    cp.rdy[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_vld", 32'(cp.vld[0]), 1);
      chk("t3_stall_pay", 32'({cp.op[0], cp.mo[0], cp.id[3:0]}), 32'(e1));
      step();
    end
    cp.rdy[0] = 1'b1;
    step();
    chk("t3_id2", 32'(cp.id[3:0]), 2);
    step();
    chk("t3_done", 32'(cp.done[0]), 1);
    chk("t3_sent", 32'(cp.sent[15:0]), 3);
    chk("t3_sb_empty", exp_q.size(), 0);

    // looping with a stop while entry 1 is pending
    cp.loop = 2'b01;
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
    exp_q.push_back(e0); exp_q.push_back(e1);
    pulse_start(2'b01);
    chk("t4_id0", 32'(cp.id[3:0]), 0);
    step();
    step();
    chk("t4_id2", 32'(cp.id[3:0]), 2);
    step();
    chk("t4_wrap", 32'(cp.id[3:0]), 0);
    step();
    chk("t4_id1b", 32'(cp.id[3:0]), 1);
    cp.rdy[0] = 1'b0;
    cp.stop = 2'b01;
    step();
    cp.stop = '0;
    chk("t4_hold_vld",  32'(cp.vld[0]), 1);
    chk("t4_hold_id",   32'(cp.id[3:0]), 1);
    chk("t4_hold_busy", 32'(cp.busy[0]), 1);
    step();
    step();
    cp.rdy[0] = 1'b1;
    step();
    chk("t4_done", 32'(cp.done[0]), 1);
    chk("t4_vld",  32'(cp.vld[0]), 0);
    chk("t4_sent", 32'(cp.sent[15:0]), 5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_quiet", 32'({cp.vld[0], cp.busy[0]}), 0);
    end
    chk("t4_sb_empty", exp_q.size(), 0);

    // load to busy channel 0 rejected, load to idle channel 1 accepted
    cp.rdy[0] = 1'b0;
    pulse_start(2'b01);
    chk("t5_busy", 32'(cp.busy[0]), 1);
    load(0, 0, DEL, 1'b1, 15, 1'b0);
    chk("t5_ld_err", 32'(cp.ld_err), 1);
    load(1, 1, FLUSH, 1'b0, 9, 1'b1);
    chk("t5_ld_ok", 32'(cp.ld_err), 0);
    chk("t5_ram_keep", 32'({cp.op[0], cp.mo[0], cp.id[3:0]}), 32'(e0));
    cp.stop = 2'b01;
    step();
    cp.stop = '0;
    exp_q.push_back(e0);
    cp.rdy[0] = 1'b1;
    step();
    chk("t5_stop_done", 32'(cp.done[0]), 1);
    cp.loop = '0;
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
    pulse_start(2'b01);
    wait_done0("t5_replay_done");
    chk("t5_replay_sent", 32'(cp.sent[15:0]), 3);
    pulse_start(2'b10);
    chk("t5_c1_vld", 32'(cp.vld[1]), 1);
    chk("t5_c1_e0",  32'({cp.op[1], cp.mo[1], cp.id[7:4]}), 32'(pay(WRITE, 1'b0, 4'd5)));
    step();
    chk("t5_c1_e1",  32'({cp.op[1], cp.mo[1], cp.id[7:4]}), 32'(pay(FLUSH, 1'b0, 4'd9)));
    step();
    chk("t5_c1_done", 32'(cp.done[1]), 1);
    chk("t5_c1_sent", 32'(cp.sent[31:16]), 2);

    // reset in the middle of playback on both channels
    sb_en = 1'b0;
    cp.loop = 2'b11;
    pulse_start(2'b11);
    step();
    step();
    chk("t6_busy", 32'(cp.busy), 3);
    rst = 1'b1;
    step();
    chk("t6_vld",  32'(cp.vld), 0);
    chk("t6_op",   32'(cp.op), 0);
    chk("t6_sent", cp.sent, 0);
    chk("t6_busy_rst", 32'(cp.busy), 0);
    chk("t6_done_rst", 32'(cp.done), 0);
    rst = 1'b0;
    cp.loop = '0;
    step();
    chk("t6_no_done", 32'(cp.done), 0);
    exp_q.delete();
    sb_en = 1'b1;
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
    pulse_start(2'b01);
    wait_done0("t6_restart_done");
    chk("t6_restart_sent", 32'(cp.sent[15:0]), 3);
    chk("t6_sb_empty", exp_q.size(), 0);
    sb_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_player.md
# cmd_player

Parametrised multi-channel command sequencer that replays a run-time-loadable script of {opcode, mode, id} commands on NCH independent valid/ready channels. It replaces fixed compile-time stimulus tables with a per-channel script RAM and adds start/stop control, looping, programmable inter-command gaps and per-channel status. It sits between the host/test control logic and the command consumers, one channel per consumer port.

## Interface
- NCH, 2: number of independent channels.
- DEPTH, 16: script entries per channel; AW = $clog2(DEPTH).
- GAP_W, 8: width of the inter-command gap field.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ld_en  in  1  script write strobe.
- ld_ch  in  $clog2(NCH)  target channel.
- ld_addr  in  AW  entry index.
- ld_op  in  opcode  entry opcode.
- ld_mo  in  1  entry mode bit.
- ld_id  in  ID_SZ  entry id.
- ld_last  in  1  entry is end of script.
- ld_err  out  1  one-cycle pulse: write rejected, target channel busy.
- start  in  NCH  per-channel start pulse.
- stop  in  NCH  per-channel stop pulse.
- loop  in  NCH  per-channel replay mode, sampled at start.
- gap  in  NCH*GAP_W  per-channel idle cycles between commands, sampled at start.
- vld  out  NCH  command valid.
- rdy  in  NCH  consumer ready.
- op  out  NCH opcode  command opcode.
- mo  out  NCH  command mode.
- id  out  NCH*ID_SZ  command id.
- busy  out  NCH  channel not IDLE.
- done  out  NCH  one-cycle pulse on return to IDLE.
- sent  out  NCH*16  handshakes since last start, saturating.

## Operation
- Per-channel FSM: IDLE, SEND, GAP.
- IDLE: vld=0, op=DEL, mo=0, id=0. On start (and no stop), go to SEND with ptr=0, sent=0, and latch loop and gap.
- SEND: vld=1, payload = script[ptr], held stable until vld&&rdy. The channel never drops vld without a handshake.
- Handshake: sent+1, saturating at 16'hFFFF. An entry is the end of script if ld_last was set or ptr==DEPTH-1.
  - End of script with loop=0, or stop pending: go to IDLE and pulse done.
  - End of script with loop=1: ptr=0.
  - Otherwise: ptr+1.
  - If gap==0, go straight to SEND (back-to-back). Otherwise go to GAP.
- GAP: vld=0 for exactly gap cycles, then SEND.
- stop in GAP: go to IDLE next cycle and pulse done.
- stop in SEND: recorded as pending, takes effect at the next handshake.
- start while busy: ignored.
- start and stop in the same cycle in IDLE: stop wins; nothing starts.
- ld_en to a busy channel: write dropped, ld_err pulses. Otherwise the entry is written at the next edge.
- Loads to different channels and playback on other channels are independent.

## Timing
- Reset values: vld=0, op=DEL, mo=0, id=0, busy=0, done=0, ld_err=0, sent=0, all FSMs IDLE.
- Script RAM is not reset; its contents survive rst.
- start sampled at edge t gives vld=1 with entry 0 from t+1.
- With gap=0 and rdy held high, throughput is one command per cycle per channel.
- With gap=g, there are exactly g vld-low cycles between a handshake and the next vld.
- done asserts in the cycle after the final handshake, coincident with busy falling.
- A script write at edge t is visible to a start sampled at t+1.
- rst mid-operation: vld low at the next edge, no done pulse.

## Structure
- Package pkg holds: opcode and DEL (existing), ID_SZ, a cmd_t struct {opcode op; logic mo; logic [ID_SZ-1:0] id; logic last}, and a state enum.
- Sub-module cmd_player_ch contains one channel's FSM, script RAM, counters and output registers.
- The top level is a generate loop over NCH plus ld_ch decode and ld_err generation.

## Test plan
- 3-entry script (last on entry 2), loop=0, gap=0, rdy=1: start → 3 consecutive vld cycles with ids 0,1,2, then done=1, sent=3.
- Same script with gap=2: exactly 2 vld-low cycles between commands; total 7 cycles from first vld to done.
- rdy low for 5 cycles mid-entry 1: vld and payload stay stable for those 5 cycles; no entry skipped or duplicated.
- loop=1: ids 0,1,2,0,1…; stop asserted while entry 1 is pending → that handshake completes, then done, with no further vld.
- Load to channel 0 while busy → ld_err pulse and RAM unchanged; a simultaneous load to idle channel 1 succeeds.
- rst mid-SEND with NCH=2: both vld low next cycle, op=DEL, sent=0; a restart replays the preserved script.
